vga_sync_rx: RTL and testbench
==============================

// Module: vga_sync_rx
// PURPOSE
//  Sink end of the 640x480 VGA timing interface: samples HS/VS on the pixel strobe, recovers pixel
//  coordinates and data-enable, and declares lock once the timing matches the expected raster.
//  Used in the bench as the checker for the timing generator, and on-chip to time-align overlays
//  (frog/square renderers) driven from a foreign sync source.
// PARAMETERS
//  H_ACTIVE    640  visible pixels per line
//  H_BP        48   pixel strobes from HS deassert to first visible pixel
//  H_TOTAL     800  pixel strobes per line
//  V_ACTIVE    480  visible lines per frame
//  V_BP        33   lines from VS deassert to first visible line
//  V_TOTAL     525  lines per frame
//  LOCK_FRAMES 2    consecutive good frames required to assert lock (1..15)
// PORTS
//  i_clk       in   1   system clock (100 MHz)
//  i_rst_n     in   1   asynchronous active-low reset
//  i_pix_stb   in   1   pixel strobe, one i_clk wide (25 MHz rate); all sampling gated by it
//  i_hs        in   1   horizontal sync, active-low, same clock domain
//  i_vs        in   1   vertical sync, active-low, same clock domain
//  o_x         out  10  recovered pixel column 0..H_ACTIVE-1; 0 when o_de=0
//  o_y         out  9   recovered line 0..V_ACTIVE-1; 0 when o_de=0
//  o_de        out  1   high while (o_x,o_y) is a visible pixel
//  o_frame_stb out  1   one-clk pulse on each detected VS deassert edge
//  o_locked    out  1   timing matches parameters for LOCK_FRAMES frames
//  o_err       out  1   one-clk pulse on any line/frame length mismatch while ALIGN/LOCKED
//  o_h_total   out  11  measured strobes in last complete line (feature-dependent)
//  o_v_total   out  11  measured lines in last complete frame (feature-dependent)
// BEHAVIOUR
//  - Reset: all outputs 0, h_cnt=v_cnt=0, good-frame count 0, FSM=SEARCH.
//  - Without i_pix_stb, no state changes. hs_q/vs_q hold the previous strobe's samples.
//  - HS edge = hs_q==0 && i_hs==1. VS edge = vs_q==0 && i_vs==1.
//  - h_cnt: on an HS edge, 0. Otherwise +1, saturating at 2047.
//  - v_cnt: on a VS edge, 0. On an HS edge, +1, saturating at 2047.
//  - Same-strobe HS+VS edges: VS wins (v_cnt=0, h_cnt=0, one line not counted).
//  - o_de=1 iff FSM!=SEARCH and H_BP<=h_cnt<H_BP+H_ACTIVE and V_BP<=v_cnt<V_BP+V_ACTIVE.
//  - o_x=h_cnt-H_BP and o_y=v_cnt-V_BP when o_de=1, else 0.
//  - Latency: registered, valid on the i_clk after the sampling strobe.
//  - FSM SEARCH: wait for first VS edge -> ALIGN; good=0.
//  - FSM ALIGN: each HS edge checks h_cnt+1==H_TOTAL; each VS edge checks v_cnt+1==V_TOTAL
//    (first line/frame after SEARCH not checked).
//  - Mismatch: good=0, o_err pulse. A good frame (all lines ok + V ok) increments good;
//    good==LOCK_FRAMES -> LOCKED.
//  - FSM LOCKED: o_locked=1. Any mismatch -> o_err pulse, o_locked=0 next clk, ALIGN, good=0.
//  - o_frame_stb pulses on every VS edge in any state. Sync held low forever leaves counters
//    saturated and raises no error.
//  - i_rst_n low mid-frame: immediate return to reset state. Relock needs 1 VS + LOCK_FRAMES frames.
// CONFIGURATION
//  `VGA_RX_MEASURE_EN defined:
//    - o_h_total is loaded with h_cnt+1 on each HS edge.
//    - o_v_total is loaded with v_cnt+1 on each VS edge (saturated values pass through).
//  `VGA_RX_MEASURE_EN undefined: o_h_total=o_v_total=0 constantly; lock/err behaviour unchanged.
// STRUCTURE
//  - Package vga_pkg: 640x480 timing constants (H_*/V_*) shared with the generator.
//  - vga_pkg also holds the rx_state_t enum {SEARCH, ALIGN, LOCKED}.
//  - Sub-module sync_edge_det (one per sync): strobe-gated sample register, rise-edge pulse output.
//  - Counters, checker and FSM stay in vga_sync_rx.
// TESTING
//  - Reset + 3 frames of nominal 800x525 timing -> o_locked rises at the VS edge ending frame 3;
//    o_err never pulses.
//  - Locked, line 100 given 801 strobes -> o_err 1 pulse, o_locked 0 next clk;
//    relocks after 2 further good frames.
//  - Locked: o_de first high with o_x=0,o_y=0 at h_cnt=48,v_cnt=33; last high with o_x=639,o_y=479;
//    exactly 307200 o_de strobes per frame.
//  - HS and VS deassert on the same strobe -> h_cnt=v_cnt=0, o_frame_stb pulses, no o_err.
//  - i_rst_n low mid-line 200 while locked -> all outputs 0 asynchronously; FSM SEARCH after release.
//  - MEASURE_EN with 1056x628 timing -> o_h_total=1056, o_v_total=628, o_locked stays 0,
//    o_err each line.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: 640x480 raster constants shared by the timing generator and receiver,
// the receiver FSM states, and a saturating 11-bit increment.
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = 800;
  localparam int V_ACTIVE = 480;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = 525;
  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} rx_state_t;
  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return &v ? v : v + 11'd1;
  endfunction
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: strobe-gated sample of an active-low sync; pulses on its deassert (rising) edge.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic stb,
  input  logic sync,
  output logic rise
);
  logic q;
  // Resets to the idle (deasserted) level so release of reset never fakes an edge.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= 1'b1;
    else if (stb) q <= sync;
  assign rise = stb && !q && sync;
endmodule

// File: rtl/vga_sync_rx.sv
// vga_sync_rx: recovers pixel coordinates/DE from HS/VS and locks onto the expected raster.
// Define VGA_RX_MEASURE_EN to report measured line/frame lengths on o_h_total/o_v_total.
module vga_sync_rx #(
  parameter int H_ACTIVE    = vga_pkg::H_ACTIVE,
  parameter int H_BP        = vga_pkg::H_BP,
  parameter int H_TOTAL     = vga_pkg::H_TOTAL,
  parameter int V_ACTIVE    = vga_pkg::V_ACTIVE,
  parameter int V_BP        = vga_pkg::V_BP,
  parameter int V_TOTAL     = vga_pkg::V_TOTAL,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pix_stb,
  input  logic        i_hs,
  input  logic        i_vs,
  output logic [9:0]  o_x,
  output logic [8:0]  o_y,
  output logic        o_de,
  output logic        o_frame_stb,
  output logic        o_locked,
  output logic        o_err,
  output logic [10:0] o_h_total,
  output logic [10:0] o_v_total
);
  import vga_pkg::*;
  logic hs_edge, vs_edge, mis, de_nxt;
  logic h_skip, h_skip_nxt, frame_bad, frame_bad_nxt;
  logic [10:0] h_cnt, v_cnt, h_nxt, v_nxt;
  logic [3:0] good, good_nxt;
  rx_state_t state, state_nxt;

  sync_edge_det u_hs (.clk(i_clk), .rst_n(i_rst_n), .stb(i_pix_stb), .sync(i_hs), .rise(hs_edge));
  sync_edge_det u_vs (.clk(i_clk), .rst_n(i_rst_n), .stb(i_pix_stb), .sync(i_vs), .rise(vs_edge));

  always_comb begin
    h_nxt = hs_edge ? '0 : sat_inc(h_cnt);
    v_nxt = vs_edge ? '0 : (hs_edge ? sat_inc(v_cnt) : v_cnt);
    mis = state != SEARCH &&
          ((hs_edge && !h_skip && h_cnt != 11'(H_TOTAL - 1)) ||
           (vs_edge && v_cnt != 11'(V_TOTAL - 1)));
    state_nxt = state;
    good_nxt = good;
    h_skip_nxt = h_skip;
    frame_bad_nxt = frame_bad;
    if (state == SEARCH) begin
      if (vs_edge) begin
        state_nxt = ALIGN;
        good_nxt = '0;
        h_skip_nxt = 1'b1;
        frame_bad_nxt = 1'b0;
      end
    end else begin
      if (hs_edge) h_skip_nxt = 1'b0;
      if (mis) begin
        state_nxt = ALIGN;
        good_nxt = '0;
        frame_bad_nxt = 1'b1;
      end
      // A frame counts only if neither its lines nor its own length mismatched.
      if (vs_edge) begin
        frame_bad_nxt = 1'b0;
        if (state == ALIGN && !mis && !frame_bad) begin
          good_nxt = good + 4'd1;
          state_nxt = (good + 4'd1 == 4'(LOCK_FRAMES)) ? LOCKED : ALIGN;
        end
      end
    end
    de_nxt = state_nxt != SEARCH &&
             h_nxt >= 11'(H_BP) && h_nxt < 11'(H_BP + H_ACTIVE) &&
             v_nxt >= 11'(V_BP) && v_nxt < 11'(V_BP + V_ACTIVE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= SEARCH;
      h_cnt <= '0;
      v_cnt <= '0;
      good <= '0;
      h_skip <= 1'b0;
      frame_bad <= 1'b0;
      o_x <= '0;
      o_y <= '0;
      o_de <= 1'b0;
      o_locked <= 1'b0;
      o_err <= 1'b0;
      o_frame_stb <= 1'b0;
    end else begin
      o_err <= mis;
      o_frame_stb <= vs_edge;
      if (i_pix_stb) begin
        state <= state_nxt;
        h_cnt <= h_nxt;
        v_cnt <= v_nxt;
        good <= good_nxt;
        h_skip <= h_skip_nxt;
        frame_bad <= frame_bad_nxt;
        o_locked <= state_nxt == LOCKED;
        o_de <= de_nxt;
        o_x <= de_nxt ? 10'(h_nxt - 11'(H_BP)) : '0;
        o_y <= de_nxt ? 9'(v_nxt - 11'(V_BP)) : '0;
      end
    end

`ifdef VGA_RX_MEASURE_EN
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_h_total <= '0;
      o_v_total <= '0;
    end else begin
      if (hs_edge) o_h_total <= sat_inc(h_cnt);
      if (vs_edge) o_v_total <= sat_inc(v_cnt);
    end
`else
  assign o_h_total = '0;
  assign o_v_total = '0;
`endif
endmodule

// File: tb/tb_vga_sync_rx.sv
// tb_vga_sync_rx: directed check of vga_sync_rx on a scaled-down 16x12 raster
// (8x6 visible, back porches 3/2) so whole frames stay short.
module tb_vga_sync_rx;
`ifdef VGA_RX_MEASURE_EN
  localparam bit MEAS = 1'b1;
`else
  localparam bit MEAS = 1'b0;
`endif
  logic i_clk = 1'b0, i_rst_n = 1'b0, i_pix_stb = 1'b0, i_hs = 1'b1, i_vs = 1'b1;
  logic [9:0] o_x;
  logic [8:0] o_y;
  logic o_de, o_frame_stb, o_locked, o_err;
  logic [10:0] o_h_total, o_v_total;
  int n_cmp = 0, n_fail = 0;
  int n_stb = 0, cur_l = 0, cur_p = 0, f_de = 0, f_err = 0, f_fs = 0, tot_err = 0;
  int first_p = -1, first_l = -1, first_x = -1, first_y = -1, last_x = -1, last_y = -1;
  int rise_idx = -1, err_idx = -1, err_lock = -1, pre_lock = -1, snap = 0;
  logic prev_lock = 1'b0;

  vga_sync_rx #(.H_ACTIVE(8), .H_BP(3), .H_TOTAL(16), .V_ACTIVE(6), .V_BP(2), .V_TOTAL(12),
                .LOCK_FRAMES(2)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pix_stb(i_pix_stb), .i_hs(i_hs), .i_vs(i_vs),
    .o_x(o_x), .o_y(o_y), .o_de(o_de), .o_frame_stb(o_frame_stb), .o_locked(o_locked),
    .o_err(o_err), .o_h_total(o_h_total), .o_v_total(o_v_total));

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One pixel strobe followed by an idle clock; outputs are sampled just after the strobe edge.
  task automatic strobe(input logic hs, input logic vs);
    i_hs = hs;
    i_vs = vs;
    i_pix_stb = 1'b1;
    @(posedge i_clk);
    #1;
    i_pix_stb = 1'b0;
    if (o_de) begin
      if (f_de == 0) begin
        first_p = cur_p; first_l = cur_l; first_x = int'(o_x); first_y = int'(o_y);
      end
      last_x = int'(o_x);
      last_y = int'(o_y);
      f_de++;
    end
    if (o_err) begin
      if (f_err == 0) begin
        err_idx = n_stb; err_lock = int'(o_locked); pre_lock = int'(prev_lock);
      end
      f_err++;
      tot_err++;
    end
    f_fs += int'(o_frame_stb);
    if (o_locked && !prev_lock) rise_idx = n_stb;
    prev_lock = o_locked;
    n_stb++;
    @(posedge i_clk);
    #1;
  endtask

  // HS low on the last two strobes of a line, VS low on the last two lines of a frame.
  task automatic line(input int l, input int len, input int vtot);
    for (int p = 0; p < len; p++) begin
      cur_l = l;
      cur_p = p;
      strobe(p < len - 2, l < vtot - 2);
    end
  endtask

  task automatic frame(input int htot, input int vtot, input int long_l);
    f_de = 0; f_err = 0; f_fs = 0;
    for (int l = 0; l < vtot; l++) line(l, (l == long_l) ? htot + 1 : htot, vtot);
  endtask

  task automatic reset_dut();
    i_rst_n = 1'b0;
    i_hs = 1'b1;
    i_vs = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    prev_lock = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_x", o_x, 0);
    chk("rst_y", o_y, 0);
    chk("rst_flags", {o_de, o_frame_stb, o_locked, o_err}, 0);
    chk("rst_totals", {o_h_total, o_v_total}, 0);
    reset_dut();
    frame(16, 12, -1);
    chk("search_de", f_de, 0);
    chk("search_fs", f_fs, 0);
    frame(16, 12, -1);
    frame(16, 12, -1);
    chk("lock_before_f3_vs", o_locked, 0);
    frame(16, 12, -1);
    chk("lock_rise_idx", rise_idx, 576);
    chk("locked", o_locked, 1);
    chk("de_per_frame", f_de, 48);
    chk("de_first_h", first_p, 3);
    chk("de_first_v", first_l, 2);
    chk("de_first_xy", {first_x[15:0], first_y[15:0]}, 0);
    chk("de_last_x", last_x, 7);
    chk("de_last_y", last_y, 5);
    chk("fs_per_frame", f_fs, 1);
    chk("nominal_err", tot_err, 0);
    frame(16, 12, 4);
    chk("long_line_err", f_err, 1);
    chk("err_idx", err_idx, 849);
    chk("lock_at_err", err_lock, 0);
    chk("lock_before_err", pre_lock, 1);
    frame(16, 12, -1);
    frame(16, 12, -1);
    chk("relock_pending", o_locked, 0);
    chk("relock_no_err", f_err, 0);
    frame(16, 12, -1);
    chk("relocked", o_locked, 1);
    chk("relock_idx", rise_idx, 1345);
    f_de = 0; f_err = 0; f_fs = 0;
    for (int l = 0; l < 5; l++) line(l, 16, 12);
    for (int p = 0; p < 8; p++) begin
      cur_l = 5; cur_p = p;
      strobe(1'b1, 1'b1);
    end
    chk("mid_de", o_de, 1);
    chk("mid_x", o_x, 4);
    chk("mid_y", o_y, 3);
    i_hs = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    i_hs = 1'b1;
    chk("gated_x_hold", o_x, 4);
    strobe(1'b1, 1'b1);
    chk("gated_x_next", o_x, 5);
    i_rst_n = 1'b0;
    #2;
    chk("async_rst_flags", {o_de, o_frame_stb, o_locked, o_err}, 0);
    chk("async_rst_xy", {o_x, o_y}, 0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    prev_lock = 1'b0;
    frame(16, 12, -1);
    chk("post_rst_search_de", f_de, 0);
    chk("post_rst_search_fs", f_fs, 0);
    frame(16, 12, -1);
    frame(16, 12, -1);
    chk("post_rst_unlocked", o_locked, 0);
    frame(16, 12, -1);
    chk("post_rst_relock", o_locked, 1);
    reset_dut();
    frame(21, 15, -1);
    frame(21, 15, -1);
    frame(21, 15, -1);
    chk("meas_err_each_line", f_err, 15);
    chk("meas_unlocked", o_locked, 0);
    chk("meas_h_total", o_h_total, MEAS ? 21 : 0);
    chk("meas_v_total", o_v_total, MEAS ? 15 : 0);
    snap = tot_err;
    repeat (2100) strobe(1'b0, 1'b0);
    chk("held_low_no_err", tot_err - snap, 0);
    chk("held_low_no_de", o_de, 0);
    strobe(1'b1, 1'b0);
    chk("sat_h_total", o_h_total, MEAS ? 2047 : 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
